btn_debounce_ctrl: RTL and testbench

- Upstream conditioner for the board push-button that sets the LED-chaser direction input.
- Synchronises the raw pad, rejects bounce and glitches, and emits a clean level plus single-cycle event pulses: press, release and long-press.
- Maintains a press-toggled state bit, so downstream stages can take either a momentary level or a latched mode.
- Sits between the top-level pad input and the LED shift controller, in the same clk domain.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_debounce_ctrl_if.sv | 22 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/btn_debounce_ctrl.sv | 115 +++++++++++
 tb/tb_btn_debounce_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding,
// production timing defaults and a short-timing set for simulation.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms debounce and 1 s long-press at 100 MHz
  localparam int DEB_CNT_DEF  = 1_000_000;
  localparam int LONG_CNT_DEF = 100_000_000;
  localparam int CNT_W_DEF    = 27;

  // Short timing so simulations reach every state in a few dozen cycles
  localparam int DEB_CNT_SIM  = 4;
  localparam int LONG_CNT_SIM = 20;

endpackage

// File: rtl/btn_debounce_ctrl_if.sv
// Button pad and conditioned event signals, bundled as one port.
// The master side drives the raw pad; the slave side is the conditioner.
interface btn_debounce_ctrl_if;

  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;
  logic btn_toggle;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_long, btn_toggle
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_long, btn_toggle
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Push-button conditioner: synchronises the pad, debounces both edges,
// and produces a clean level, press/release/long-press pulses and a
// press-toggled mode bit. One counter is reused by every FSM state.
module btn_debounce_ctrl
  import btn_pkg::*;
#(
  parameter int DEB_CNT  = DEB_CNT_DEF,
  parameter int LONG_CNT = LONG_CNT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_debounce_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  logic       w_sync;
  btn_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic       r_long_done;
  logic       r_level;
  logic       r_press;
  logic       r_release;
  logic       r_long;
  logic       r_toggle;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.btn_raw),
    .o_q   (w_sync)
  );

  // Debounce FSM with registered level, pulse and toggle outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_long_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_toggle    <= 1'b0;
    end else begin
      // pulses default low so each one lasts a single cycle
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sync) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_sync) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state     <= ST_HELD;
            r_cnt       <= '0;
            r_level     <= 1'b1;
            r_press     <= 1'b1;
            r_toggle    <= ~r_toggle;
            r_long_done <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          // long pulse may coincide with the first low sample
          if (r_cnt == LONG_LAST && !r_long_done) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
          end
          if (!w_sync) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= '0;
          end else if (r_cnt != LONG_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          // a return high is bounce: back to HELD, long_done retained
          if (w_sync) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level   = r_level;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
  assign bus.btn_long    = r_long;
  assign bus.btn_toggle  = r_toggle;

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Bench for btn_debounce_ctrl with short timing. A window-based model
// predicts the output vector for every clock edge and queues it; a
// monitor on the falling edge pops and compares.
module tb_btn_debounce_ctrl;
  import btn_pkg::*;

  localparam int DEB = DEB_CNT_SIM;
  localparam int LNG = LONG_CNT_SIM;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
    logic tog;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  btn_debounce_ctrl_if bus_if ();

  btn_debounce_ctrl #(
    .DEB_CNT  (DEB),
    .LONG_CNT (LNG),
    .CNT_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t sb_q[$];

  // model state: raw samples and synchronised samples per edge since reset
  bit rawh[$];
  bit synh[$];
  bit m_level, m_tog, m_ldone;
  int m_p;
  int exp_press_n = 0, exp_rel_n = 0, exp_long_n = 0;
  int obs_press_n = 0, obs_rel_n = 0, obs_long_n = 0;

  function automatic exp_t dut_vec();
    exp_t v;
    v.level = bus_if.btn_level;
    v.press = bus_if.btn_press;
    v.rel   = bus_if.btn_release;
    v.lng   = bus_if.btn_long;
    v.tog   = bus_if.btn_toggle;
    return v;
  endfunction

  // true when synh[lo..hi] all equal v
  function automatic bit win(int lo, int hi, bit v);
    if (lo < 0) return 1'b0;
    for (int i = lo; i <= hi; i++)
      if (synh[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(string name, logic [4:0] act, logic [4:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  task automatic chk_int(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: an edge is accepted once DEB+1 consecutive synchronised
  // samples disagree with the current level; a long press fires once LNG
  // consecutive high samples follow the press edge (or a bounce return).
  always @(posedge clk) begin : model
    exp_t e;
    int n;
    cyc++;
    if (!rst_n) begin
      rawh.delete();
      synh.delete();
      m_level = 1'b0;
      m_tog   = 1'b0;
      m_ldone = 1'b0;
      m_p     = 0;
    end else begin
      e = '0;
      rawh.push_back(bus_if.btn_raw);
      n = rawh.size() - 1;
      synh.push_back((n >= 2) ? rawh[n-2] : 1'b0);
      if (!m_level) begin
        if (win(n - DEB, n, 1'b1)) begin
          m_level = 1'b1;
          m_tog   = ~m_tog;
          m_ldone = 1'b0;
          m_p     = n;
          e.press = 1'b1;
          exp_press_n++;
        end
      end else begin
        if (!m_ldone && (n - LNG >= m_p) && win(n - LNG, n - 1, 1'b1)) begin
          m_ldone = 1'b1;
          e.lng   = 1'b1;
          exp_long_n++;
        end else if (win(n - DEB, n, 1'b0)) begin
          m_level = 1'b0;
          e.rel   = 1'b1;
          exp_rel_n++;
        end
      end
      e.level = m_level;
      e.tog   = m_tog;
      sb_q.push_back(e);
    end
  end

  // Monitor: during reset outputs must be zero, otherwise match the queue
  always @(negedge clk) begin : monitor
    exp_t a;
    exp_t r;
    a = dut_vec();
    if (!rst_n) begin
      chk("reset_outputs", a, 5'b0);
    end else if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk("out_vec", a, r);
      if (a.press) obs_press_n++;
      if (a.rel)   obs_rel_n++;
      if (a.lng)   obs_long_n++;
    end
  end

  // raw held at v for cyc_n cycles, changing just after the rising edge
  task automatic hold(bit v, int cyc_n);
    @(posedge clk);
    #2;
    bus_if.btn_raw = v;
    repeat (cyc_n - 1) @(posedge clk);
  endtask

  task automatic do_reset(int cyc_n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("reset_immediate", dut_vec(), 5'b0);
    repeat (cyc_n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus_if.btn_raw = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    hold(1'b0, 5);
    // clean press and release
    hold(1'b1, 30);
    hold(1'b0, 15);
    // glitch shorter than the debounce window
    hold(1'b1, 3);
    hold(1'b0, 15);
    // bouncing release
    hold(1'b1, 12);
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 2);
      hold(1'b1, 2);
    end
    hold(1'b0, 15);
    // two short presses toggle the mode bit back
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 10);
      hold(1'b0, 15);
    end
    // reset while held, button still down afterwards
    hold(1'b1, 15);
    do_reset(3);
    hold(1'b1, 20);
    hold(1'b0, 15);
    // long hold, counter saturates
    hold(1'b1, 60);
    hold(1'b0, 15);
    // randomised runs with occasional resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3));
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 26));
    end
    hold(1'b0, 20);
    @(negedge clk);
    #1;
    chk_int("press_count", obs_press_n, exp_press_n);
    chk_int("release_count", obs_rel_n, exp_rel_n);
    chk_int("long_count", obs_long_n, exp_long_n);
    chk_int("queue_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
